// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: takes a PC from the PC unit, performs one
// single-beat instruction-memory read, and hands instruction + PC (+ fault
// flag) to decode. Self-starts at RST_PC after reset.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module ifu_fetch #(
  parameter logic [`CPU_WIDTH-1:0] RST_PC  = 32'h8000_0000,
  parameter int unsigned           TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [`CPU_WIDTH-1:0]  i_pc,
  input  logic                   i_pre_valid,
  output logic                   o_pre_ready,
  output logic                   o_mem_req,
  output logic [`CPU_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_gnt,
  input  logic                   i_mem_rvalid,
  input  logic [`INS_WIDTH-1:0]  i_mem_rdata,
  input  logic                   i_mem_err,
  output logic [`INS_WIDTH-1:0]  o_ins,
  output logic [`CPU_WIDTH-1:0]  o_pc,
  output logic                   o_fetch_err,
  output logic                   o_post_valid,
  input  logic                   i_post_ready
);

  localparam logic [`INS_WIDTH-1:0] NOP = 32'h0000_0013;
  localparam logic [7:0]            TMO = TIMEOUT[7:0];

  typedef enum logic [2:0] {BOOT, IDLE, REQ, WAIT, HOLD} state_t;

  state_t                 state;
  logic [`CPU_WIDTH-1:0]  pc_q;
  logic [7:0]             cnt;
  logic                   drop_pend;

  logic                   accept;
  logic                   rv_live;
  logic [7:0]             cnt_nxt;

  // Handshake and response qualification derived from current state
  always_comb begin
    o_pre_ready = (state == IDLE) || ((state == HOLD) && i_post_ready);
    accept      = i_pre_valid && o_pre_ready;
    rv_live     = i_mem_rvalid && !drop_pend;
    cnt_nxt     = cnt + 8'd1;
  end

  // Fetch FSM with registered memory-side and decode-side outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= BOOT;
      pc_q         <= RST_PC;
      cnt          <= '0;
      drop_pend    <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_ins        <= NOP;
      o_pc         <= RST_PC;
      o_fetch_err  <= 1'b0;
      o_post_valid <= 1'b0;
    end else begin
      // A late response after a timeout is swallowed whatever the state.
      if (i_mem_rvalid && drop_pend)
        drop_pend <= 1'b0;

      case (state)
        BOOT: begin
          pc_q       <= RST_PC;
          o_mem_req  <= 1'b1;
          o_mem_addr <= RST_PC;
          state      <= REQ;
        end

        IDLE, HOLD: begin
          if ((state == HOLD) && i_post_ready) begin
            o_post_valid <= 1'b0;
            state        <= IDLE;
          end
          // In HOLD, accept implies i_post_ready, so this overrides the drain.
          if (accept) begin
            if (i_pc[1:0] != 2'b00) begin
              o_fetch_err  <= 1'b1;
              o_ins        <= NOP;
              o_pc         <= i_pc;
              o_post_valid <= 1'b1;
              state        <= HOLD;
            end else begin
              pc_q       <= i_pc;
              o_mem_req  <= 1'b1;
              o_mem_addr <= {i_pc[`CPU_WIDTH-1:2], 2'b00};
              state      <= REQ;
            end
          end
        end

        REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            cnt       <= '0;
            // Same-cycle grant+response is handled as WAIT seeing rvalid.
            if (rv_live) begin
              o_ins        <= i_mem_err ? NOP : i_mem_rdata;
              o_fetch_err  <= i_mem_err;
              o_pc         <= pc_q;
              o_post_valid <= 1'b1;
              state        <= HOLD;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (rv_live) begin
            o_ins        <= i_mem_err ? NOP : i_mem_rdata;
            o_fetch_err  <= i_mem_err;
            o_pc         <= pc_q;
            o_post_valid <= 1'b1;
            state        <= HOLD;
          end else if (cnt_nxt == TMO) begin
            o_ins        <= NOP;
            o_fetch_err  <= 1'b1;
            o_pc         <= pc_q;
            o_post_valid <= 1'b1;
            drop_pend    <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: the bench plays the PC unit, the instruction
// memory and decode; expected deliveries go into a scoreboard queue when the
// fetch is launched and are compared when decode receives them.

module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_pc = '0;
  logic        i_pre_valid = 1'b0;
  logic        o_pre_ready;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_err = 1'b0;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_fetch_err;
  logic        o_post_valid;
  logic        i_post_ready = 1'b0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RST_PC(32'h8000_0000), .TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc         (i_pc),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_err    (i_mem_err),
    .o_ins        (o_ins),
    .o_pc         (o_pc),
    .o_fetch_err  (o_fetch_err),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string t);
    chk({t, "_mem_req"},    {31'b0, o_mem_req},    32'd0);
    chk({t, "_mem_addr"},   o_mem_addr,            32'd0);
    chk({t, "_ins"},        o_ins,                 NOP);
    chk({t, "_pc"},         o_pc,                  RST);
    chk({t, "_fetch_err"},  {31'b0, o_fetch_err},  32'd0);
    chk({t, "_post_valid"}, {31'b0, o_post_valid}, 32'd0);
    chk({t, "_pre_ready"},  {31'b0, o_pre_ready},  32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (o_mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'b0, o_mem_req}, 32'd1);
  endtask

  // Memory side: grant after gdly cycles, respond rdly cycles after the grant
  task automatic serve(input int gdly, input int rdly, input logic [31:0] data,
                       input logic err, input logic [31:0] addr);
    wait_req();
    for (int i = 0; i < gdly; i++) begin
      chk("req_hold",      {31'b0, o_mem_req},   32'd1);
      chk("addr_hold",     o_mem_addr,           addr);
      chk("pre_ready_req", {31'b0, o_pre_ready}, 32'd0);
      @(negedge clk);
    end
    chk("req_at_gnt",  {31'b0, o_mem_req}, 32'd1);
    chk("addr_at_gnt", o_mem_addr,         addr);
    i_mem_gnt = 1'b1;
    if (rdly == 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = data;
      i_mem_err    = err;
    end
    @(negedge clk);
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_err    = 1'b0;
    chk("req_drop", {31'b0, o_mem_req}, 32'd0);
    if (rdly > 0) begin
      for (int i = 1; i < rdly; i++) begin
        chk("pv_wait", {31'b0, o_post_valid}, 32'd0);
        @(negedge clk);
      end
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = data;
      i_mem_err    = err;
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      i_mem_err    = 1'b0;
    end
  endtask

  // Decode side: wait for delivery, compare with scoreboard, stall, release
  task automatic consume(input int hold, input logic offer, input logic [31:0] pc);
    int   n = 0;
    exp_t e;
    while (o_post_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("post_valid", {31'b0, o_post_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=delivery expected=none");
      e = '{ins: NOP, pc: RST, err: 1'b0};
    end else begin
      e = sb.pop_front();
    end
    chk("ins",       o_ins,                e.ins);
    chk("pc",        o_pc,                 e.pc);
    chk("fetch_err", {31'b0, o_fetch_err}, {31'b0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_ins",       o_ins,                 e.ins);
      chk("stall_pc",        o_pc,                  e.pc);
      chk("stall_pv",        {31'b0, o_post_valid}, 32'd1);
      chk("stall_pre_ready", {31'b0, o_pre_ready},  32'd0);
    end
    i_post_ready = 1'b1;
    #1;
    chk("release_pre_ready", {31'b0, o_pre_ready}, 32'd1);
    if (offer) begin
      i_pre_valid = 1'b1;
      i_pc        = pc;
    end
    @(negedge clk);
    i_post_ready = 1'b0;
    i_pre_valid  = 1'b0;
    if (offer && pc[1:0] == 2'b00) begin
      chk("chained_req", {31'b0, o_mem_req},    32'd1);
      chk("chained_pv",  {31'b0, o_post_valid}, 32'd0);
    end else if (!offer) begin
      chk("pv_drop", {31'b0, o_post_valid}, 32'd0);
    end
  endtask

  task automatic issue(input logic [31:0] pc);
    int n = 0;
    while (o_pre_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_ready_idle", {31'b0, o_pre_ready}, 32'd1);
    i_pre_valid = 1'b1;
    i_pc        = pc;
    @(negedge clk);
    i_pre_valid = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 reset_vals("rst_async");
    repeat (2) @(negedge clk);
    reset_vals("rst_held");
    rst_n = 1'b1;

    // Boot fetch at RST_PC, decode stalls 5 cycles, next PC chained on release
    sb.push_back('{ins: 32'h0010_0093, pc: RST, err: 1'b0});
    serve(0, 1, 32'h0010_0093, 1'b0, RST);
    consume(5, 1'b1, 32'h8000_0004);

    // Grant held off 3 cycles: request/address must stay put for 4 cycles
    sb.push_back('{ins: 32'h0020_0113, pc: 32'h8000_0004, err: 1'b0});
    serve(3, 1, 32'h0020_0113, 1'b0, 32'h8000_0004);
    consume(0, 1'b0, '0);

    // Misaligned PC: fault delivered next cycle without a memory request
    sb.push_back('{ins: NOP, pc: 32'h8000_0002, err: 1'b1});
    issue(32'h8000_0002);
    chk("misalign_no_req", {31'b0, o_mem_req}, 32'd0);
    consume(0, 1'b0, '0);

    // Bus error response
    sb.push_back('{ins: NOP, pc: 32'h8000_0008, err: 1'b1});
    issue(32'h8000_0008);
    serve(0, 2, 32'hDEAD_BEEF, 1'b1, 32'h8000_0008);
    consume(0, 1'b0, '0);

    // Grant and response in the same cycle
    sb.push_back('{ins: 32'h0030_0193, pc: 32'h8000_000C, err: 1'b0});
    issue(32'h8000_000C);
    serve(0, 0, 32'h0030_0193, 1'b0, 32'h8000_000C);
    consume(0, 1'b0, '0);

    // Timeout after 4 WAIT cycles
    sb.push_back('{ins: NOP, pc: 32'h8000_0010, err: 1'b1});
    issue(32'h8000_0010);
    wait_req();
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_pv_low", {31'b0, o_post_valid}, 32'd0);
      @(negedge clk);
    end
    chk("tmo_pv_high", {31'b0, o_post_valid}, 32'd1);
    consume(0, 1'b0, '0);

    // Late response lands in the next fetch's WAIT and must be dropped
    sb.push_back('{ins: 32'h0040_0213, pc: 32'h8000_0014, err: 1'b0});
    issue(32'h8000_0014);
    wait_req();
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    chk("stale_dropped", {31'b0, o_post_valid}, 32'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0040_0213;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    consume(0, 1'b0, '0);

    // Reset pulse during WAIT, stale response right after, restart at RST_PC
    issue(32'h8000_0018);
    wait_req();
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_vals("rst_wait");
    @(negedge clk);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hBAD1_BAD1;
    rst_n        = 1'b1;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    sb.push_back('{ins: 32'h0050_0293, pc: RST, err: 1'b0});
    serve(0, 1, 32'h0050_0293, 1'b0, RST);
    consume(0, 1'b0, '0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
